// File: rtl/seg14_scan_ctrl.sv
// Scan scheduler for a multiplexed 14-segment display: double-buffered message store,
// dead-time blanking between digits, PWM brightness gating and frame-based scrolling.
module seg14_scan_ctrl #(
    parameter int DIGITS  = 12,
    parameter int MSG_LEN = 16,
    parameter int SEG_W   = 14,
    parameter int DEAD    = 2
) (
`ifdef USE_POWER_PINS
    inout  wire                         vdd,
    inout  wire                         vss,
`endif
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr_i,
    input  logic [SEG_W-1:0]            wr_data_i,
    input  logic                        swap_i,
    input  logic [15:0]                 scan_div_i,
    input  logic [3:0]                  bright_i,
    input  logic                        scroll_en_i,
    input  logic [7:0]                  scroll_div_i,
    output logic [DIGITS-1:0]           sel_o,
    output logic [SEG_W-1:0]            segm_o,
    output logic                        frame_done_o
);

    localparam int AW      = $clog2(MSG_LEN);
    localparam int DW      = $clog2(DIGITS);
    localparam int MIN_LEN = DEAD + 2;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        drive_len_q, drive_len_d;
    logic [15:0]        slot_len, drive_len_now;
    logic [DW-1:0]      digit_q, digit_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [AW-1:0]      offset_q;
    logic [7:0]         fcnt_q;
    logic               swap_pend_q;
    logic               frame_end, do_copy, pwm_on;
    logic [AW-1:0]      rd_idx;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic [SEG_W-1:0]   segm_q, segm_d;
    logic               frame_done_q, frame_done_d;
    logic [SEG_W-1:0]   shadow_q [MSG_LEN];
    logic [SEG_W-1:0]   active_q [MSG_LEN];

    assign slot_len      = (scan_div_i < 16'(MIN_LEN)) ? 16'(MIN_LEN) : scan_div_i;
    assign drive_len_now = slot_len - 16'(DEAD);
    assign rd_idx        = offset_q + AW'(digit_q);
    assign pwm_on        = (bright_i == 4'hF) || (pwm_q < bright_i);
    assign do_copy       = swap_pend_q && ((state_q == IDLE) || frame_end);
    assign wr_ready_o    = ~swap_pend_q;

    assign sel_o         = sel_q;
    assign segm_o        = segm_q;
    assign frame_done_o  = frame_done_q;

    // Outputs are computed from the current state and registered, giving one cycle of latency;
    // enable is folded in so a disable blanks the pins on the very next cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        digit_d      = digit_q;
        drive_len_d  = drive_len_q;
        pwm_d        = pwm_q + 4'd1;
        sel_d        = '0;
        segm_d       = '0;
        frame_done_d = 1'b0;
        frame_end    = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    cnt_d       = '0;
                    digit_d     = '0;
                    drive_len_d = drive_len_now;
                end
                BLANK: begin
                    if (cnt_q == 16'(DEAD - 1)) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        pwm_d   = '0;
                    end
                end
                DRIVE: begin
                    if (pwm_on) begin
                        sel_d          = '0;
                        sel_d[digit_q] = 1'b1;
                        segm_d         = active_q[rd_idx];
                    end
                    if (cnt_q == drive_len_q - 16'd1) begin
                        state_d     = BLANK;
                        cnt_d       = '0;
                        drive_len_d = drive_len_now;
                        if (digit_q == DW'(DIGITS - 1)) begin
                            digit_d      = '0;
                            frame_end    = 1'b1;
                            frame_done_d = 1'b1;
                        end else begin
                            digit_d = digit_q + DW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            drive_len_q  <= 16'(MIN_LEN - DEAD);
            digit_q      <= '0;
            pwm_q        <= '0;
            sel_q        <= '0;
            segm_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drive_len_q  <= drive_len_d;
            digit_q      <= digit_d;
            pwm_q        <= pwm_d;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A pending swap blocks writes, so a write and the copy never hit the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend_q <= 1'b0;
        end else if (!swap_pend_q && swap_i) begin
            swap_pend_q <= 1'b1;
        end else if (do_copy) begin
            swap_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_valid_i && wr_ready_o) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (do_copy) begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // The >= keeps the step cadence sane if scroll_div is lowered below the running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
            fcnt_q   <= '0;
        end else if (!scroll_en_i) begin
            offset_q <= '0;
            fcnt_q   <= '0;
        end else if (frame_end) begin
            if (fcnt_q >= scroll_div_i) begin
                fcnt_q   <= '0;
                offset_q <= offset_q + AW'(1);
            end else begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/seg14_scan_ctrl.md
Name: seg14_scan_ctrl

Overview:
- Scan scheduler for the 12-digit, 14-segment multiplexed display. It replaces hard-wired per-digit character selection with a programmable, double-buffered message store.
- Sequences one digit per time slot and inserts dead-time blanking between digits. Applies brightness PWM and optional scrolling over a 16-entry message buffer.
- Sits between a host write port and the display pins (sel, segm).

Parameters:
- DIGITS, 12, number of display digits (sel width).
- MSG_LEN, 16, message buffer entries (power of 2).
- SEG_W, 14, segment pattern width.
- DEAD, 2, blank cycles at the start of every digit slot.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vdd, vss  inout  1  power pins, present only under USE_POWER_PINS.
- enable  input  1  scanning enable.
- wr_valid  input  1  shadow-buffer write request.
- wr_ready  output  1  shadow buffer accepts writes.
- wr_addr  input  4  shadow entry index.
- wr_data  input  SEG_W  segment pattern to store.
- swap  input  1  request to copy shadow to active at the next frame boundary.
- scan_div  input  16  slot length in clk cycles.
- bright  input  4  brightness: 0 = off, 15 = full.
- scroll_en  input  1  scrolling enable.
- scroll_div  input  8  frames per scroll step, minus 1.
- sel  output  DIGITS  one-hot digit select, registered.
- segm  output  SEG_W  segment drive, registered.
- frame_done  output  1  one-cycle pulse after the last digit slot of a frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: sel=0, segm=0, frame_done=0, wr_ready=1.
  - Internal state: both buffers all zero, digit index=0, scroll offset=0, frame count=0, PWM count=0, state IDLE, swap_pend=0.
- Effective slot length: L = max(scan_div, DEAD+2).
- FSM:
  - IDLE: sel=0, segm=0. Moves to BLANK with digit=0 when enable=1.
  - BLANK: lasts DEAD cycles, sel=0, segm=0. Then moves to DRIVE.
  - DRIVE: lasts L-DEAD cycles.
    - sel = one-hot(digit).
    - segm = active[(offset+digit) mod MSG_LEN].
    - Output is gated by PWM: driven when bright==15 or pwm_cnt<bright, otherwise sel=0 and segm=0.
    - pwm_cnt is a free-running 4-bit counter, cleared on entry to DRIVE.
  - End of DRIVE:
    - digit<DIGITS-1: digit+1, back to BLANK.
    - digit==DIGITS-1: frame boundary. digit=0, frame_done=1 for one cycle, back to BLANK, or to IDLE if enable=0.
  - enable=0 in any state: next cycle goes to IDLE, outputs 0, digit=0, no frame_done.
- Outputs are registered: the pin value reflects the state and counters of the previous cycle (1-cycle latency).
- Write handshake:
  - A write commits on a clk edge where wr_valid=1 and wr_ready=1: shadow[wr_addr] <= wr_data.
  - Writes with wr_ready=0 are dropped; the host must hold wr_valid until it sees wr_ready.
- Swap:
  - swap=1 (sampled while swap_pend=0) sets swap_pend=1 and drops wr_ready to 0 on the next cycle.
  - In IDLE, or at a frame boundary, all shadow entries are copied to active in one cycle. Then swap_pend clears and wr_ready returns to 1 on the following cycle.
  - The copy at the frame boundary takes effect for digit 0 of the next frame.
  - A swap coincident with a write in the same cycle: the write lands first and is included in the copy.
  - swap while swap_pend=1 is ignored.
- Scroll:
  - With scroll_en=1, frame count increments per frame boundary. When frame count == scroll_div, frame count clears and offset = (offset+1) mod MSG_LEN, applied from the next frame.
  - scroll_en=0 clears offset and frame count immediately.
- scan_div, bright and scroll_div may change at any time. A scan_div change applies from the next slot start.

Test Plan:
1. Reset values: assert rst_n=0 mid-DRIVE -> sel=0, segm=0, frame_done=0 and wr_ready=1 immediately (asynchronous). After release with enable=1, scanning restarts at digit 0 with a 2-cycle blank.
2. Basic scan: write shadow[k]=k+1 for k=0..11, swap with enable=0, then enable=1, scan_div=8, bright=15. Each slot shows 2 cycles sel=0 then 6 cycles sel=1<<k, segm=k+1. frame_done pulses every 96 cycles.
3. Swap handshake: issue swap mid-frame. wr_ready=0 from the next cycle until 1 cycle after the frame boundary, and a write during this window is dropped. The new patterns appear exactly from digit 0 of the next frame.
4. Scroll: shadow[k]=k for k=0..15, scroll_en=1, scroll_div=1. Digit 0 shows 0,0,1,1,2,2,... across frames, with a 15->0 wrap on the indices (digit 11 at offset 5 shows entry 0). scroll_en=0 -> digit 0 shows 0 next frame.
5. Brightness: scan_div=34 (32 drive cycles), bright=4 -> 8 of 32 drive cycles active, as 4 active then 12 blank, repeated. bright=0 -> sel stays 0 for the whole slot.
6. Slot clamp and disable: scan_div=1 -> slot length is 4 (2 blank, 2 drive). Drop enable mid-slot -> outputs 0 on the next cycle, no frame_done, and the restart begins at digit 0.
